// File: rtl/pipe_pkg.sv
// pipe_pkg: debug FSM states and stage-register indices shared by the pipeline controller.
package pipe_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED, EXITED} pipe_state_t;
    localparam int IF_IDX  = 0;
    localparam int ID_IDX  = 1;
    localparam int EX_IDX  = 2;
    localparam int MEM_IDX = 3;
    localparam int WB_IDX  = 4;
endpackage

// File: rtl/mc_timer.sv
// mc_timer: counts EX cycles of a multi-cycle op; busy until its final cycle, done on that cycle.
module mc_timer #(
    parameter int MC_LAT = 34
) (
    input  logic clock,
    input  logic reset,
    input  logic mc_req,
    output logic busy,
    output logic done
);
    localparam int W = $clog2(MC_LAT);
    localparam logic [W-1:0] LAST = W'(MC_LAT - 1);
    logic [W-1:0] mc_cnt;
    assign done = mc_req && mc_cnt == LAST;
    assign busy = mc_req && !done;
    always_ff @(posedge clock or posedge reset)
        if (reset) mc_cnt <= '0;
        else mc_cnt <= busy ? mc_cnt + W'(1) : '0;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-stage stall/flush arbitration with multi-cycle EX timing and debug halt/drain/resume.
module pipe_ctrl #(
    parameter int STAGES = 5,
    parameter int EX_IDX = 2,
    parameter int MC_LAT = 34,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_load_use_i,
    input  logic              id_branch_i,
    input  logic              ex_redirect_i,
    input  logic              mc_req_i,
    input  logic              exit_i,
    input  logic              halt_req_i,
    input  logic              resume_i,
    output logic [STAGES-1:0] stall_o,
    output logic [STAGES-1:0] flush_o,
    output logic              id_redirect_en_o,
    output logic              ex_redirect_en_o,
    output logic              mc_done_o,
    output logic              halted_o,
    output logic              exited_o,
    output logic [CNT_W-1:0]  stall_cycles_o
);
    import pipe_pkg::*;
    localparam int DW = $clog2(STAGES);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(STAGES - 1);
    pipe_state_t state, state_nx;
    logic [DW-1:0] drain_cnt;
    logic mc_busy, hold, draining, exited;
    mc_timer #(.MC_LAT(MC_LAT)) u_mc_timer (
        .clock  (clock),
        .reset  (reset),
        .mc_req (mc_req_i),
        .busy   (mc_busy),
        .done   (mc_done_o)
    );
    // The halt request cycle already drains; the last drain cycle freezes the whole pipe.
    assign hold     = state == HALTED || state == EXITED || (state == DRAIN && drain_cnt == DRAIN_LAST);
    assign draining = !hold && (state == DRAIN || (state == RUN && halt_req_i));
    assign halted_o = state == HALTED || state == EXITED;
    assign exited_o = exited;
    always_comb begin
        stall_o = '0;
        flush_o = '0;
        id_redirect_en_o = 1'b0;
        ex_redirect_en_o = 1'b0;
        if (hold) stall_o = '1;
        else if (mc_busy) begin
            stall_o[EX_IDX:0] = '1;
            flush_o[EX_IDX+1] = 1'b1;
        end else if (ex_redirect_i) begin
            flush_o[ID_IDX] = 1'b1;
            flush_o[EX_IDX] = 1'b1;
            ex_redirect_en_o = 1'b1;
        end else if (id_load_use_i) begin
            stall_o[ID_IDX:IF_IDX] = '1;
            flush_o[EX_IDX] = 1'b1;
        end else if (id_branch_i) begin
            flush_o[ID_IDX] = 1'b1;
            id_redirect_en_o = 1'b1;
        end
        if (draining) begin
            stall_o[IF_IDX] = 1'b1;
            flush_o[ID_IDX] = !stall_o[ID_IDX];
            id_redirect_en_o = 1'b0;
            ex_redirect_en_o = 1'b0;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            RUN:     state_nx = exit_i ? EXITED : halt_req_i ? DRAIN : RUN;
            DRAIN:   state_nx = exit_i ? EXITED : drain_cnt == DRAIN_LAST ? HALTED : DRAIN;
            HALTED:  state_nx = resume_i ? RUN : HALTED;
            default: state_nx = EXITED;
        endcase
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state        <= RUN;
            drain_cnt    <= '0;
            exited       <= 1'b0;
            stall_cycles_o <= '0;
        end else begin
            state     <= state_nx;
            drain_cnt <= state_nx == DRAIN ? drain_cnt + DW'(!mc_busy) : '0;
            exited    <= exited || state_nx == EXITED;
            if (stall_o[IF_IDX] && !(&stall_cycles_o)) stall_cycles_o <= stall_cycles_o + CNT_W'(1);
        end
endmodule
